led_panel_ctrl: RTL and testbench

LED_PANEL_CTRL -- requirements
Module: led_panel_ctrl

---
 rtl/screen_leds_pkg.sv | 14 +
 rtl/button_repeat.sv | 90 +++++++++
 rtl/led_panel_ctrl.sv | 85 ++++++++
 tb/tb_led_panel_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/screen_leds_pkg.sv
// Shared constants for the screen LED panel: row reset value,
// default last row index and the button FSM state encoding.
package screen_leds_pkg;

  localparam logic [2:0] ROW_RESET   = 3'd2;
  localparam int         ROW_MAX_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

endpackage

// File: rtl/button_repeat.sv
// One button: 2-flop synchronizer, debouncer, auto-repeat FSM.
// Ports: clk, rst (sync, high), btn (raw), req (1-cycle pulse).
module button_repeat
  import screen_leds_pkg::*;
#(
  parameter int DEB_CYCLES    = 240000,
  parameter int REPEAT_CYCLES = 2100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic req
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);

  logic          s1, s2;
  logic          lvl;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt, rcnt_nx;
  btn_state_e    st, st_nx;

  // Any sample equal to the current level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      lvl  <= 1'b0;
      dcnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 != lvl) begin
        if (dcnt == DLAST) begin
          lvl  <= s2;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end else begin
        dcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= ST_IDLE;
      rcnt <= '0;
    end else begin
      st   <= st_nx;
      rcnt <= rcnt_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    rcnt_nx = rcnt;
    req     = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (lvl) begin
          st_nx   = ST_HELD;
          rcnt_nx = '0;
          req     = 1'b1;
        end
      end
      ST_HELD, ST_REPEAT: begin
        if (!lvl) begin
          st_nx   = ST_IDLE;
          rcnt_nx = '0;
        end else if (rcnt == RLAST) begin
          st_nx   = ST_REPEAT;
          rcnt_nx = '0;
          req     = 1'b1;
        end else begin
          rcnt_nx = rcnt + RW'(1);
        end
      end
      default: begin
        st_nx   = ST_IDLE;
        rcnt_nx = '0;
      end
    endcase
  end

endmodule

// File: rtl/led_panel_ctrl.sv
// Row/byte LED panel control: two auto-repeat buttons, updates
// committed on vsync fall. Ports: clk, rst, inc_row, inc_byte,
// vsync (active-low), row_led, byte_led, disp, row_pend, byte_pend.
module led_panel_ctrl
  import screen_leds_pkg::*;
#(
  parameter int DEB_CYCLES    = 240000,
  parameter int REPEAT_CYCLES = 2100000,
  parameter int ROW_MAX       = ROW_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_row,
  input  logic       inc_byte,
  input  logic       vsync,
  output logic [2:0] row_led,
  output logic [7:0] byte_led,
  output logic [7:0] disp,
  output logic       row_pend,
  output logic       byte_pend
);

  localparam logic [2:0] RMAX = 3'(ROW_MAX);

  logic row_req, byte_req;
  logic v1, v2, v3;
  logic commit;

  button_repeat #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_row (
    .clk(clk),
    .rst(rst),
    .btn(inc_row),
    .req(row_req)
  );

  button_repeat #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_byte (
    .clk(clk),
    .rst(rst),
    .btn(inc_byte),
    .req(byte_req)
  );

  // Reset high so the first cycle cannot look like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b1;
      v2 <= 1'b1;
      v3 <= 1'b1;
    end else begin
      v1 <= vsync;
      v2 <= v1;
      v3 <= v2;
    end
  end

  assign commit = v3 & ~v2;

  // A request landing with a commit keeps pend set for itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_led   <= ROW_RESET;
      byte_led  <= '0;
      row_pend  <= 1'b0;
      byte_pend <= 1'b0;
    end else begin
      if (commit && row_pend) begin
        row_led <= (row_led >= RMAX) ? 3'd0 : row_led + 3'd1;
      end
      if (commit && byte_pend) begin
        byte_led <= byte_led + 8'd1;
      end
      row_pend  <= row_req | (row_pend & ~commit);
      byte_pend <= byte_req | (byte_pend & ~commit);
    end
  end

  assign disp = byte_led;

endmodule

// File: tb/tb_led_panel_ctrl.sv
// Self-checking bench for led_panel_ctrl with small timing
// parameters and a request-counting reference model.
module tb_led_panel_ctrl;

  localparam int DEB = 4;
  localparam int REP = 20;
  localparam int RMX = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       inc_row;
  logic       inc_byte;
  logic       vsync;
  logic [2:0] row_led;
  logic [7:0] byte_led;
  logic [7:0] disp;
  logic       row_pend;
  logic       byte_pend;

  int n_tests = 0;
  int n_fail  = 0;
  int mrow;
  int mbyte;

  led_panel_ctrl #(
    .DEB_CYCLES   (DEB),
    .REPEAT_CYCLES(REP),
    .ROW_MAX      (RMX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inc_row  (inc_row),
    .inc_byte (inc_byte),
    .vsync    (vsync),
    .row_led  (row_led),
    .byte_led (byte_led),
    .disp     (disp),
    .row_pend (row_pend),
    .byte_pend(byte_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    inc_row  = 1'b0;
    inc_byte = 1'b0;
    vsync    = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    mrow  = 2;
    mbyte = 0;
  endtask

  task automatic vfall();
    vsync = 1'b0;
    cyc(4);
    vsync = 1'b1;
    cyc(4);
  endtask

  task automatic bump_row(input int k);
    for (int i = 0; i < k; i++)
      mrow = (mrow >= RMX) ? 0 : mrow + 1;
  endtask

  task automatic bump_byte(input int k);
    for (int i = 0; i < k; i++)
      mbyte = (mbyte + 1) % 256;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".row"}, int'(row_led), mrow);
    check({tag, ".byte"}, int'(byte_led), mbyte);
    check({tag, ".disp"}, int'(disp), mbyte);
    check({tag, ".rpend"}, int'(row_pend), 0);
    check({tag, ".bpend"}, int'(byte_pend), 0);
  endtask

  // Clean press of h cycles, then release and let it settle.
  task automatic press(input bit row, input int h);
    if (row) inc_row = 1'b1;
    else     inc_byte = 1'b1;
    cyc(h);
    inc_row  = 1'b0;
    inc_byte = 1'b0;
    cyc(DEB + 8);
  endtask

  // Hold length giving exactly k requests.
  function automatic int hold_len(input int k);
    if (k == 0) return 0;
    return (k - 1) * REP + int'($urandom_range(8, 14));
  endfunction

  // Hold both buttons while vsync falls every 10 cycles.
  task automatic hold_run(input int hr, input int hb, input int ph);
    int hmax;
    hmax = (hr > hb) ? hr : hb;
    for (int t = 0; t < hmax + 40; t++) begin
      inc_row  = (t < hr);
      inc_byte = (t < hb);
      vsync    = (((t + ph) % 10) < 5);
      cyc(1);
    end
    vsync = 1'b1;
    cyc(4);
    vfall();
    vfall();
  endtask

  initial begin
    int b0, kr, kb, k;

    do_reset();
    check_state("reset");

    for (int i = 0; i < 3; i++) begin
      vfall();
      check_state("idle_vsync");
    end

    // Bouncy press yields one request.
    inc_byte = 1'b1; cyc(2);
    inc_byte = 1'b0; cyc(2);
    inc_byte = 1'b1; cyc(6);
    inc_byte = 1'b0; cyc(DEB + 8);
    check("bounce.pend", int'(byte_pend), 1);
    check("bounce.hold", int'(byte_led), 0);
    vfall();
    bump_byte(1);
    check_state("bounce");

    // Reset mid-debounce abandons the press.
    do_reset();
    inc_row = 1'b1;
    cyc(4);
    rst = 1'b1;
    inc_row = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(15);
    check_state("rst_mid");
    vfall();
    check_state("rst_mid_v");

    // Row wrap from reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 8);
      vfall();
      bump_row(1);
      check("row_seq", int'(row_led), mrow);
    end
    check("row_wrap", int'(row_led), 0);

    // Two presses before vsync collapse into one.
    press(1'b0, 8);
    press(1'b0, 8);
    check("sat.pend", int'(byte_pend), 1);
    check("sat.hold", int'(byte_led), mbyte);
    vfall();
    bump_byte(1);
    check_state("sat");

    // Request in the same cycle as the commit.
    press(1'b0, 8);
    b0 = mbyte;
    inc_byte = 1'b1;
    cyc(4);
    vsync = 1'b0;
    cyc(4);
    check("same.byte", int'(byte_led), (b0 + 1) % 256);
    check("same.pend", int'(byte_pend), 1);
    inc_byte = 1'b0;
    vsync = 1'b1;
    cyc(DEB + 8);
    vfall();
    bump_byte(2);
    check_state("same");

    // Random hold episodes.
    for (int e = 0; e < 10; e++) begin
      kr = $urandom_range(0, 3);
      kb = $urandom_range(0, 3);
      hold_run(hold_len(kr), hold_len(kb), $urandom_range(0, 9));
      bump_row(kr);
      bump_byte(kb);
      check_state("rand");
    end

    // Drive byte up to 255, then wrap.
    k = 255 - mbyte;
    if (k > 0) begin
      hold_run(0, (k - 1) * REP + 10, 3);
      bump_byte(k);
    end
    check("pre255", int'(byte_led), 255);
    press(1'b0, 8);
    vfall();
    bump_byte(1);
    check_state("wrap");

    // 70-cycle hold: first request plus three repeats.
    hold_run(0, 70, 0);
    bump_byte(4);
    check_state("hold70");
    check("hold70.val", int'(byte_led), 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
